// File: rtl/stepper_slot_positioner.sv
// Purpose : moves a 4-wire stepper to an absolute slot position (slot*SLOT_PITCH), then holds it for a timed dwell.
// Latency : the first step lands STEP_DIV cycles after MOVE entry; done = (|dist| + 1 + max(DWELL_TICKS,1)) * STEP_DIV cycles.
// Backpressure: none. Start edges seen while busy are dropped, and abort returns to IDLE on the next edge.
//
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   start                       level input; a rising edge in IDLE requests a move
//   slot, half_step             target slot and step mode, sampled on the accepted start edge
//   abort                       level; stops MOVE/DWELL, or drops a coincident start in IDLE
//   busy, done, at_pos          status: busy in MOVE/DWELL, one-cycle done pulse, holding position
//   cur_pos                     absolute position in step units (modulo 2^POS_W)
//   coil                        coil drive {A,B,C,D}; 0000 whenever IDLE
module stepper_slot_positioner #(
  parameter int STEP_DIV    = 100000,
  parameter int POS_W       = 16,
  parameter int SLOT_W      = 2,
  parameter int SLOT_PITCH  = 512,
  parameter int DWELL_TICKS = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SLOT_W-1:0] slot,
  input  logic              half_step,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              at_pos,
  output logic [POS_W-1:0]  cur_pos,
  output logic [3:0]        coil
);

  // A dwell of zero ticks still waits for one tick, so the done pulse is never
  // issued on the same edge as the arrival decision.
  localparam int DWELL_EFF = (DWELL_TICKS < 1) ? 1 : DWELL_TICKS;
  localparam int CNT_W     = $clog2(STEP_DIV);
  localparam int DWELL_W   = $clog2(DWELL_EFF + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STEP_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_EFF - 1);
  localparam logic [POS_W-1:0]   PITCH      = POS_W'(SLOT_PITCH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t               state;
  logic                 start_q;
  logic                 half_q;
  logic [2:0]           phase;
  logic [POS_W-1:0]     target;
  logic [CNT_W-1:0]     div_cnt;
  logic [DWELL_W-1:0]   dwell_cnt;

  logic                 start_edge;
  logic                 tick;
  logic [2:0]           step_amt;
  logic [2:0]           phase_up;
  logic [2:0]           phase_dn;
  logic [2:0]           phase_lat;
  logic [POS_W-1:0]     slot_target;

  // Half-step sequence. Full (wave) mode walks only the even entries.
  function automatic logic [3:0] coil_of(input logic [2:0] ph);
    logic [3:0] c;
    case (ph)
      3'd0:    c = 4'b1000;
      3'd1:    c = 4'b1100;
      3'd2:    c = 4'b0100;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0010;
      3'd5:    c = 4'b0011;
      3'd6:    c = 4'b0001;
      default: c = 4'b1001;
    endcase
    return c;
  endfunction

  always_comb begin
    start_edge  = start & ~start_q;
    tick        = (div_cnt == CNT_LAST);
    step_amt    = half_q ? 3'd1 : 3'd2;
    phase_up    = phase + step_amt;
    phase_dn    = phase - step_amt;
    // Full mode must sit on an even phase; otherwise the +/-2 steps would land
    // on the two-coil entries.
    phase_lat   = half_step ? phase : {phase[2:1], 1'b0};
    // The product is taken at POS_W bits, so large slot indices wrap silently.
    slot_target = POS_W'(slot) * PITCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      half_q    <= 1'b0;
      phase     <= 3'd0;
      target    <= '0;
      div_cnt   <= '0;
      dwell_cnt <= '0;
      cur_pos   <= '0;
      coil      <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      at_pos    <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;

      case (state)
        S_IDLE: begin
          div_cnt   <= '0;
          dwell_cnt <= '0;
          if (abort) begin
            // Abort beats a coincident start edge; the edge is consumed, not deferred.
            at_pos <= 1'b0;
          end else if (start_edge) begin
            target <= slot_target;
            half_q <= half_step;
            phase  <= phase_lat;
            coil   <= coil_of(phase_lat);
            at_pos <= 1'b0;
            busy   <= 1'b1;
            state  <= S_MOVE;
          end
        end

        S_MOVE: begin
          if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            coil    <= 4'b0000;
            at_pos  <= 1'b0;
            div_cnt <= '0;
          end else if (tick) begin
            div_cnt <= '0;
            if (cur_pos < target) begin
              cur_pos <= cur_pos + POS_W'(1);
              phase   <= phase_up;
              coil    <= coil_of(phase_up);
            end else if (cur_pos > target) begin
              cur_pos <= cur_pos - POS_W'(1);
              phase   <= phase_dn;
              coil    <= coil_of(phase_dn);
            end else begin
              // Arrival is recognised on a tick, so even a zero-length move
              // spends one full tick period in MOVE.
              state     <= S_DWELL;
              dwell_cnt <= '0;
            end
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        S_DWELL: begin
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            coil      <= 4'b0000;
            at_pos    <= 1'b0;
            div_cnt   <= '0;
            dwell_cnt <= '0;
          end else if (tick) begin
            div_cnt <= '0;
            if (dwell_cnt == DWELL_LAST) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              at_pos    <= 1'b1;
              coil      <= 4'b0000;
              dwell_cnt <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          coil  <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_slot_positioner.sv
// Bench for stepper_slot_positioner with a move-level reference model.
// Each move's expected trajectory is computed arithmetically from its start point.
// Random moves include ignored start chatter, aborts and held start levels.
module tb_stepper_slot_positioner;

  localparam int D     = 4;
  localparam int PITCH = 3;
  localparam int DW    = 2;
  localparam int SW    = 2;
  localparam int PW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] slot;
  logic          half_step;
  logic          abort;
  logic          busy;
  logic          done;
  logic          at_pos;
  logic [PW-1:0] cur_pos;
  logic [3:0]    coil;

  int checks = 0;
  int errors = 0;

  // Reference model state: absolute position and phase index.
  int m_pos   = 0;
  int m_phase = 0;

  logic [3:0] coil_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};

  always #5 clk = ~clk;

  stepper_slot_positioner #(
    .STEP_DIV   (D),
    .POS_W      (PW),
    .SLOT_W     (SW),
    .SLOT_PITCH (PITCH),
    .DWELL_TICKS(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .slot     (slot),
    .half_step(half_step),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .at_pos   (at_pos),
    .cur_pos  (cur_pos),
    .coil     (coil)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it; inputs are driven from here too.
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input bit exp_at_pos);
    check_eq({tag, "_busy"},   busy,    0);
    check_eq({tag, "_done"},   done,    0);
    check_eq({tag, "_atpos"},  at_pos,  exp_at_pos);
    check_eq({tag, "_coil"},   coil,    0);
    check_eq({tag, "_pos"},    cur_pos, m_pos & 32'hFFFF);
  endtask

  // One move. With the start edge taken as edge 0, step k lands on edge k*D,
  // arrival on edge (n+1)*D and done on edge (n+1+DW)*D.
  // ab_at > 0 raises abort before that edge; noise toggles start/slot/mode mid-move.
  task automatic run_move(input int s, input bit hs, input int ab_in, input bit hold,
                          input bit noise, input string tag);
    int tgt, pos0, dir, n, stp, ph0, cd, k, ab_at, epos, eph;
    tgt  = (s * PITCH) % (1 << PW);
    pos0 = m_pos;
    dir  = (tgt > pos0) ? 1 : ((tgt < pos0) ? -1 : 0);
    n    = (dir >= 0) ? (tgt - pos0) : (pos0 - tgt);
    stp  = hs ? 1 : 2;
    ph0  = hs ? m_phase : (m_phase & 6);
    cd   = (n + 1 + DW) * D;
    ab_at = (ab_in >= cd) ? cd - 1 : ab_in;

    slot = SW'(s); half_step = hs; abort = 1'b0; start = 1'b1;
    step_cycle();
    check_eq({tag, "_busy_rise"}, busy,    1);
    check_eq({tag, "_atpos_clr"}, at_pos,  0);
    check_eq({tag, "_coil0"},     coil,    coil_tab[ph0]);
    check_eq({tag, "_pos0"},      cur_pos, pos0);
    if (!hold) start = 1'b0;

    for (int c = 1; c <= cd; c++) begin
      if (c == ab_at) abort = 1'b1;
      if (noise && !hold) begin
        start     = 1'($urandom_range(0, 1));
        slot      = SW'($urandom);
        half_step = 1'($urandom_range(0, 1));
      end
      step_cycle();
      if (c == ab_at) begin
        k = (c - 1) / D;
        if (k > n) k = n;
        m_pos   = (pos0 + dir * k) & 32'hFFFF;
        m_phase = (ph0 + dir * stp * k) & 7;
        abort = 1'b0;
        start = 1'b0;
        check_idle({tag, "_abort"}, 0);
        step_cycle();
        check_idle({tag, "_post_abort"}, 0);
        return;
      end
      k = c / D;
      if (k > n) k = n;
      epos = (pos0 + dir * k) & 32'hFFFF;
      eph  = (ph0 + dir * stp * k) & 7;
      check_eq({tag, "_pos"},  cur_pos, epos);
      check_eq({tag, "_coil"}, coil,    (c == cd) ? 4'b0000 : coil_tab[eph]);
      check_eq({tag, "_busy"}, busy,    (c < cd) ? 1 : 0);
      check_eq({tag, "_done"}, done,    (c == cd) ? 1 : 0);
      check_eq({tag, "_atpos"}, at_pos, (c == cd) ? 1 : 0);
    end
    m_pos   = tgt;
    m_phase = (ph0 + dir * stp * n) & 7;

    if (!hold) start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      check_idle({tag, "_after"}, 1);
    end
    start = 1'b0;
    step_cycle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; slot = '0; half_step = 1'b0; abort = 1'b0;
    step_cycle();
    step_cycle();
    check_idle("reset", 0);
    rst = 1'b0;
    step_cycle();
    check_idle("reset_rel", 0);

    // Reset mid-move: two half steps toward slot 3, then an asynchronous reset.
    slot = 2'd3; half_step = 1'b1; start = 1'b1;
    step_cycle();
    start = 1'b0;
    repeat (9) step_cycle();
    check_eq("midmove_pos", cur_pos, 2);
    check_eq("midmove_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("arst_pos",  cur_pos, 0);
    check_eq("arst_coil", coil,    0);
    check_eq("arst_busy", busy,    0);
    step_cycle();
    rst = 1'b0;
    m_pos = 0; m_phase = 0;
    step_cycle();

    run_move(2, 1'b1, 0, 1'b0, 1'b0, "fwd_half");
    run_move(1, 1'b0, 0, 1'b0, 1'b0, "rev_full");
    run_move(1, 1'b1, 0, 1'b0, 1'b0, "zero_move");
    run_move(3, 1'b1, 9, 1'b0, 1'b1, "abort_mid");
    run_move(0, 1'b0, 0, 1'b0, 1'b1, "home_noise");

    // Start and abort together in IDLE: the start is dropped, at_pos cleared.
    start = 1'b1; abort = 1'b1; slot = 2'd2;
    step_cycle();
    check_idle("start_abort", 0);
    abort = 1'b0;
    step_cycle();
    step_cycle();
    check_idle("start_abort_hold", 0);
    start = 1'b0;
    step_cycle();

    // Start held high through completion gives exactly one move.
    run_move(2, 1'b1, 0, 1'b1, 1'b0, "level_start");
    run_move(3, 1'b0, 0, 1'b0, 1'b0, "after_level");

    for (int r = 0; r < 40; r++) begin
      int s, ab;
      bit hs, hold, noise;
      s     = $urandom_range(0, 3);
      hs    = 1'($urandom_range(0, 1));
      ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      hold  = ($urandom_range(0, 4) == 0);
      noise = 1'($urandom_range(0, 1));
      run_move(s, hs, ab, hold, noise, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
